inst_fetch: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: the initiator side of the instruction-memory port. It owns the program counter and drives `inst_ce`/`inst_addr` to the instruction memory. It captures the returned word into the IF/ID pipeline register and applies stall, branch redirect and exception flush. It sits between the pipeline controller/ID stage and the instruction memory, and feeds the decoder.

---
 rtl/inst_fetch_pkg.sv | 16 +
 rtl/inst_fetch_if.sv | 8 +
 rtl/inst_fetch_if_id_reg.sv | 43 ++++
 rtl/inst_fetch.sv | 68 ++++++
 tb/tb_inst_fetch.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants, bus widths, stall-vector bit positions and fetch FSM states.
package inst_fetch_pkg;
  localparam int InstBus = 32;
  localparam int InstAddrBus = 32;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [31:0] NopInst = 32'h0000_0000;
  localparam logic ChipEnable = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam int StallPcBit = 0;
  localparam int StallIfidBit = 1;
  localparam int StallIdBit = 2;
  localparam int StallExBit = 3;
  localparam int StallMemBit = 4;
  localparam int StallWbBit = 5;
  typedef enum logic {BOOT, RUN} state_e;
endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction-memory port; master is the fetch stage, slave is the memory.
interface inst_fetch_if #(parameter int W = 32);
  logic inst_ce;
  logic [W-1:0] inst_addr;
  logic [W-1:0] inst_i;
  modport master (output inst_ce, inst_addr, input inst_i);
  modport slave (input inst_ce, inst_addr, output inst_i);
endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush, stall bubble, hold and misaligned-fetch tagging.
module if_id_reg
  import inst_fetch_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         flush,
  input  logic         stall_pc,
  input  logic         stall_ifid,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] inst,
  output logic [W-1:0] id_pc,
  output logic [W-1:0] id_inst,
  output logic         id_excp_adel
);
  logic [W-1:0] pc_q, pc_d, inst_q, inst_d;
  logic adel_q, adel_d, bubble, misalign;
  // A misaligned fetch carries a NOP so the bogus word never reaches decode
  always_comb begin
    bubble = !run || flush || (stall_pc && !stall_ifid);
    misalign = |pc[1:0];
    pc_d = bubble ? W'(ZeroWord) : stall_ifid ? pc_q : pc;
    inst_d = bubble ? W'(NopInst) : stall_ifid ? inst_q : misalign ? W'(NopInst) : inst;
    adel_d = bubble ? 1'b0 : stall_ifid ? adel_q : misalign;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= W'(ZeroWord);
      inst_q <= W'(NopInst);
      adel_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inst_q <= inst_d;
      adel_q <= adel_d;
    end
  end
  assign id_pc = pc_q;
  assign id_inst = inst_q;
  assign id_excp_adel = adel_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC, BOOT/RUN state and next-PC selection feeding the IF/ID register.
// FETCH_PERF_EN adds the fetch_cnt accepted-fetch counter port.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_pc,
  input  logic              stall_ifid,
  input  logic              branch_flag,
  input  logic [INST_W-1:0] branch_target,
  input  logic              flush,
  input  logic [INST_W-1:0] flush_pc,
  inst_fetch_if.master      imem,
  output logic [INST_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_excp_adel
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);
  state_e state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d;
  logic run;
  // Flush beats both stalls; a branch seen during a PC stall is dropped and re-presented by ID
  always_comb begin
    state_d = RUN;
    run = state_q == RUN;
    pc_d = !run ? pc_q : flush ? flush_pc : stall_pc ? pc_q : branch_flag ? branch_target : pc_q + INST_W'(4);
    imem.inst_ce = run ? ChipEnable : ChipDisable;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
  end
  assign imem.inst_addr = pc_q;
  if_id_reg #(.W(INST_W)) u_if_id (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .flush(flush),
    .stall_pc(stall_pc),
    .stall_ifid(stall_ifid),
    .pc(pc_q),
    .inst(imem.inst_i),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_excp_adel(id_excp_adel)
  );
`ifdef FETCH_PERF_EN
  logic [31:0] cnt_q, cnt_d;
  always_comb cnt_d = (run && !flush && !stall_pc && !stall_ifid) ? cnt_q + 32'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign fetch_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch; expected IF/ID, PC and counter values are queued per driven cycle.
module tb_inst_fetch;
  logic clk = 0, rst_n = 0;
  logic stall_pc = 0, stall_ifid = 0, branch_flag = 0, flush = 0;
  logic [31:0] branch_target = '0, flush_pc = '0;
  logic [31:0] id_pc, id_inst, fetch_cnt;
  logic id_excp_adel;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  inst_fetch_if imem ();
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: mem_word = 32'h11;
      32'h4: mem_word = 32'h22;
      32'h8: mem_word = 32'h33;
      default: mem_word = {16'hC0DE, a[15:0]} ^ {a[31:16], 16'h0};
    endcase
  endfunction
  assign imem.inst_i = mem_word(imem.inst_addr);
  inst_fetch #(.INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall_pc(stall_pc),
    .stall_ifid(stall_ifid),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .flush(flush),
    .flush_pc(flush_pc),
    .imem(imem),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_excp_adel(id_excp_adel)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt(fetch_cnt)
`endif
  );
`ifndef FETCH_PERF_EN
  assign fetch_cnt = '0;
`endif
  typedef struct {
    logic [31:0] pc, inst, addr, cnt;
    logic adel, ce;
  } exp_t;
  exp_t q[$];
  logic m_run;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_cnt;
  logic m_adel;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_run = 0;
    m_pc = 32'h0;
    m_id_pc = 0;
    m_id_inst = 0;
    m_adel = 0;
    m_cnt = 0;
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ce"}, {31'b0, imem.inst_ce}, 32'd0);
    check({tag, "_addr"}, imem.inst_addr, 32'h0);
    check({tag, "_id_pc"}, id_pc, 32'h0);
    check({tag, "_id_inst"}, id_inst, 32'h0);
    check({tag, "_adel"}, {31'b0, id_excp_adel}, 32'd0);
`ifdef FETCH_PERF_EN
    check({tag, "_cnt"}, fetch_cnt, 32'd0);
`endif
  endtask
  task automatic step(input logic f, input logic sp, input logic si, input logic br,
                      input logic [31:0] tgt, input logic [31:0] fpc);
    exp_t e;
    flush = f;
    stall_pc = sp;
    stall_ifid = si;
    branch_flag = br;
    branch_target = tgt;
    flush_pc = fpc;
    if (!m_run || f || (sp && !si)) begin
      m_id_pc = 0;
      m_id_inst = 0;
      m_adel = 0;
    end else if (!si) begin
      m_id_pc = m_pc;
      m_adel = m_pc[1:0] != 2'b00;
      m_id_inst = m_adel ? 32'h0 : mem_word(m_pc);
    end
    if (m_run && !f && !sp && !si) m_cnt = m_cnt + 1;
    if (m_run) m_pc = f ? fpc : sp ? m_pc : br ? tgt : m_pc + 32'd4;
    m_run = 1;
    e.pc = m_id_pc;
    e.inst = m_id_inst;
    e.adel = m_adel;
    e.addr = m_pc;
    e.ce = 1;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("id_pc", id_pc, e.pc);
    check("id_inst", id_inst, e.inst);
    check("id_adel", {31'b0, id_excp_adel}, {31'b0, e.adel});
    check("inst_addr", imem.inst_addr, e.addr);
    check("inst_ce", {31'b0, imem.inst_ce}, {31'b0, e.ce});
`ifdef FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, e.cnt);
`endif
  endtask
  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1;
    #1;
    check("ce_after_release", {31'b0, imem.inst_ce}, 32'd0);
    run_n(3);
    step(0, 0, 0, 1, 32'h100, 0);
    run_n(1);
    step(1, 0, 0, 0, 0, 32'hC);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
    run_n(2);
    step(0, 1, 0, 0, 0, 0);
    run_n(2);
    step(1, 1, 0, 1, 32'h200, 32'h180);
    run_n(1);
    step(0, 0, 0, 1, 32'h102, 0);
    run_n(2);
    step(1, 0, 0, 0, 0, 32'h40);
    run_n(2);
    step(0, 1, 0, 1, 32'h300, 0);
    run_n(2);
    step(0, 0, 1, 0, 0, 0);
    run_n(1);
    step(1, 0, 1, 0, 0, 32'hFFFF_FFF8);
    run_n(3);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_reset("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    check("ce_after_rerelease", {31'b0, imem.inst_ce}, 32'd0);
    run_n(3);
    for (int i = 0; i < 300; i++) begin
      logic f, sp, si, br;
      logic [31:0] tgt, fpc;
      f = $urandom_range(0, 19) == 0;
      sp = $urandom_range(0, 5) == 0;
      si = sp ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      br = $urandom_range(0, 4) == 0;
      tgt = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      fpc = 32'($urandom_range(0, 255)) << 2;
      step(f, sp, si, br, tgt, fpc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
